// File: rtl/prefix_adder_pkg.sv
// Shared types and elaboration-time helpers for the pipelined Kogge-Stone adder.
package prefix_adder_pkg;

    typedef struct packed {
        logic g;
        logic p;
    } pg_t;

    function automatic int levels_f(input int width);
        return $clog2(width);
    endfunction

    // Prefix level after which rank boundary 'stage' sits, rounded half up.
    // Boundary 0 is the input (level 0) and boundary 'stages' is the last level.
    function automatic int cut_after_f(input int stage, input int levels, input int stages);
        return (2 * stage * levels + stages) / (2 * stages);
    endfunction

endpackage

// File: rtl/prefix_pg_cell.sv
// Kogge-Stone black cell: merges a high (G,P) group with the adjacent lower group.
module prefix_pg_cell
    import prefix_adder_pkg::*;
(
    input  pg_t hi,
    input  pg_t lo,
    output pg_t res
);

    assign res.g = hi.g | (hi.p & lo.g);
    assign res.p = hi.p & lo.p;

endmodule

// File: rtl/prefix_adder_pipe.sv
// Pipelined Kogge-Stone adder with valid/ready backpressure and STAGES register ranks.
// Define PREFIX_ADDER_SUB_EN to add the 'sub' input (result = a - b, cin ignored).
module prefix_adder_pipe
    import prefix_adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PREFIX_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int LEVELS = levels_f(WIDTH);

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;

`ifdef PREFIX_ADDER_SUB_EN
    assign b_eff   = sub ? ~b : b;
    assign cin_eff = sub | cin;
`else
    assign b_eff   = b;
    assign cin_eff = cin;
`endif

    logic [WIDTH-1:0]       px_in;
    pg_t  [WIDTH-1:0]       pg_in;

    assign px_in = a ^ b_eff;

    // Bit 0 absorbs the carry-in as g[-1]; its group P becomes 0 so every
    // finished prefix G[i:0] is directly the carry into bit i+1.
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pg_in[i].g = a[i] & b_eff[i];
            pg_in[i].p = px_in[i];
        end
        pg_in[0].g = (a[0] & b_eff[0]) | (px_in[0] & cin_eff);
        pg_in[0].p = 1'b0;
    end

    pg_t  [WIDTH-1:0] pg_q [STAGES];
    pg_t  [WIDTH-1:0] pg_d [STAGES];
    logic [WIDTH-1:0] px_q [STAGES];
    logic [STAGES-1:0] cin_q;
    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] adv;

    for (genvar r = 0; r < STAGES; r++) begin : gen_rank
        localparam int LO = cut_after_f(r, LEVELS, STAGES);
        localparam int HI = cut_after_f(r + 1, LEVELS, STAGES);

        for (genvar l = 0; l <= LEVELS; l++) begin : gen_lvl
            pg_t [WIDTH-1:0] node;

            if (l == 0) begin : g_src
                if (r == 0) begin : g_first
                    assign node = pg_in;
                end else begin : g_chain
                    assign node = pg_q[r-1];
                end
            end else if (l > LO && l <= HI) begin : g_ks
                localparam int SPAN = 1 << (l - 1);
                for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
                    if (i >= SPAN) begin : g_cell
                        prefix_pg_cell u_cell (
                            .hi  (gen_lvl[l-1].node[i]),
                            .lo  (gen_lvl[l-1].node[i-SPAN]),
                            .res (node[i])
                        );
                    end else begin : g_done
                        assign node[i] = gen_lvl[l-1].node[i];
                    end
                end
            end else begin : g_pass
                assign node = gen_lvl[l-1].node;
            end
        end

        assign pg_d[r] = gen_lvl[LEVELS].node;
    end

    // A rank may load when it is empty or its contents move on this cycle.
    always_comb begin
        logic nxt;
        nxt = out_ready;
        adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            nxt    = !v_q[k] || nxt;
            adv[k] = nxt;
        end
    end

    assign in_ready = adv[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            cin_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                pg_q[k] <= '0;
                px_q[k] <= '0;
            end
        end else begin
            if (adv[0]) begin
                v_q[0]   <= in_valid;
                pg_q[0]  <= pg_d[0];
                px_q[0]  <= px_in;
                cin_q[0] <= cin_eff;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (adv[k]) begin
                    v_q[k]   <= v_q[k-1];
                    pg_q[k]  <= pg_d[k];
                    px_q[k]  <= px_q[k-1];
                    cin_q[k] <= cin_q[k-1];
                end
            end
        end
    end

    logic [WIDTH-1:0] carry_hi;
    logic             unused_last_p;

    always_comb begin
        unused_last_p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            carry_hi[i]   = pg_q[STAGES-1][i].g;
            unused_last_p = unused_last_p ^ pg_q[STAGES-1][i].p;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign s         = px_q[STAGES-1] ^ {carry_hi[WIDTH-2:0], cin_q[STAGES-1]};
    assign cout      = carry_hi[WIDTH-1];
    assign ovf       = carry_hi[WIDTH-1] ^ carry_hi[WIDTH-2];

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: 32-bit/2-stage directed checks plus a 13-bit/3-stage stream.
module tb_prefix_adder_pipe;

    localparam int W  = 32;
    localparam int S  = 2;
    localparam int W2 = 13;
    localparam int S2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout, ovf, sub_v;
    logic [W-1:0] a, b, s;

    logic          rst2_n, in_valid2, in_ready2, cin2, out_valid2, out_ready2, cout2, ovf2;
    logic [W2-1:0] a2, b2, s2;

    int n_chk  = 0;
    int n_pass = 0;

    prefix_adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PREFIX_ADDER_SUB_EN
        .sub       (sub_v),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf)
    );

    prefix_adder_pipe #(.WIDTH(W2), .STAGES(S2)) dut13 (
        .clk       (clk),
        .rst_n     (rst2_n),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .cin       (cin2),
`ifdef PREFIX_ADDER_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .s         (s2),
        .cout      (cout2),
        .ovf       (ovf2)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // {ovf, cout, s}
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic c, input logic sb);
        logic [W-1:0] yy;
        logic [W:0]   t;
        logic         cc;
        yy = sb ? ~y : y;
        cc = sb | c;
        t  = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        return {(x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]), t};
    endfunction

    function automatic logic [W2+1:0] model2(input logic [W2-1:0] x, input logic [W2-1:0] y,
                                             input logic c);
        logic [W2:0] t;
        t = {1'b0, x} + {1'b0, y} + {{W2{1'b0}}, c};
        return {(x[W2-1] == y[W2-1]) && (t[W2-1] != x[W2-1]), t};
    endfunction

    logic [W+1:0]  sb_q[$];
    logic [W2+1:0] sb2_q[$];
    logic [W+1:0]  held;
    logic          stall_prev = 1'b0;
    logic          saw_stall  = 1'b0;
    int            n_in = 0, n_out = 0, n_in2 = 0, n_out2 = 0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            sb_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {ovf, cout, s}, held);
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(a, b, cin, sub_v));
                n_in++;
            end
            if (in_valid && !in_ready) saw_stall = 1'b1;
            if (out_valid && out_ready) begin
                n_out++;
                if (sb_q.size() == 0) check("sb_unexpected", sb_q.size(), 1);
                else check("sb_data", {ovf, cout, s}, sb_q.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            held       = {ovf, cout, s};
        end
    end

    initial forever begin
        @(negedge clk);
        if (!rst2_n) begin
            sb2_q.delete();
        end else begin
            if (in_valid2 && in_ready2) begin
                sb2_q.push_back(model2(a2, b2, cin2));
                n_in2++;
            end
            if (out_valid2 && out_ready2) begin
                n_out2++;
                if (sb2_q.size() == 0) check("w13_unexpected", sb2_q.size(), 1);
                else check("w13_sum", {ovf2, cout2, s2}, sb2_q.pop_front());
            end
        end
    end

    task automatic send_chk(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic c, input logic sb, input logic [W+1:0] exp);
        int k;
        int lat;
        @(posedge clk); #1;
        a = x; b = y; cin = c; sub_v = sb; in_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_rdy"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_lat"}, lat, S);
        check(tag, {ovf, cout, s}, exp);
    endtask

    typedef struct {
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic         c;
        logic [W+1:0] e;
    } vec_t;

    vec_t vecs[6] = '{
        '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 34'h1_0000_0000},
        '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 34'h2_8000_0000},
        '{32'h1234_5678, 32'h8765_4321, 1'b1, 34'h0_9999_999A},
        '{32'h8000_0000, 32'h8000_0000, 1'b0, 34'h3_0000_0000},
        '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 34'h1_FFFF_FFFF},
        '{32'h0000_0000, 32'h0000_0000, 1'b1, 34'h0_0000_0001}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int late_out;
        rst_n = 1'b0; in_valid = 1'b1; a = 32'hDEAD_BEEF; b = 32'h1; cin = 1'b1;
        sub_v = 1'b0; out_ready = 1'b1;
        rst2_n = 1'b0; in_valid2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0; out_ready2 = 1'b1;

        fork
            begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                check("rst_valid", out_valid, 0);
                check("rst_data", {ovf, cout, s}, 0);
                @(posedge clk); #1;
                in_valid = 1'b0;
                rst_n    = 1'b1;
                @(negedge clk);
                check("rdy_after_rst", in_ready, 1);

                foreach (vecs[i])
                    send_chk($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].c, 1'b0, vecs[i].e);
`ifdef PREFIX_ADDER_SUB_EN
                send_chk("sub_5_7", 32'd5, 32'd7, 1'b0, 1'b1, 34'h0_FFFF_FFFE);
                send_chk("sub_7_5", 32'd7, 32'd5, 1'b1, 1'b1, 34'h1_0000_0002);
`endif

                // 8-beat stream with a 5-cycle consumer stall in the middle
                @(posedge clk); #1;
                fork
                    begin
                        for (int i = 0; i < 8; i++) begin
                            int k;
                            a = 32'(32'h1357_9BDF * (i + 1));
                            b = 32'hFFFF_0000 >> i;
                            cin = 1'(i & 1);
                            sub_v = 1'b0;
                            in_valid = 1'b1;
                            k = 0;
                            @(negedge clk);
                            while (!in_ready && k < 20) begin
                                @(negedge clk);
                                k++;
                            end
                            check("bp_accept", in_ready, 1);
                            @(posedge clk); #1;
                        end
                        in_valid = 1'b0;
                    end
                    begin
                        repeat (3) @(posedge clk);
                        #1 out_ready = 1'b0;
                        repeat (5) @(posedge clk);
                        #1 out_ready = 1'b1;
                    end
                join
                repeat (10) @(posedge clk);
                #1;
                check("bp_in_ready_fell", saw_stall, 1);
                check("bp_drained", sb_q.size(), 0);
                check("bp_count", n_out, n_in);

                // two beats parked in the pipe, then reset mid-cycle
                out_ready = 1'b0;
                a = 32'h11; b = 32'h22; cin = 1'b0; in_valid = 1'b1;
                @(posedge clk); #1;
                a = 32'h33; b = 32'h44;
                @(posedge clk); #1;
                in_valid = 1'b0;
                @(negedge clk);
                check("inflight_valid", out_valid, 1);
                check("inflight_rdy", in_ready, 0);
                @(posedge clk); #2;
                rst_n = 1'b0;
                #1;
                check("async_rst_valid", out_valid, 0);
                check("async_rst_data", {ovf, cout, s}, 0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                out_ready = 1'b1;
                late_out = 0;
                repeat (8) begin
                    @(negedge clk);
                    if (out_valid) late_out++;
                end
                check("no_stale_beats", late_out, 0);
            end
            begin
                repeat (2) @(posedge clk);
                #1 rst2_n = 1'b1;
                for (int n = 0; n < 400; n++) begin
                    in_valid2  = ($urandom_range(0, 3) != 0);
                    out_ready2 = ($urandom_range(0, 3) != 0);
                    a2   = 13'($urandom);
                    b2   = 13'($urandom);
                    cin2 = 1'($urandom);
                    @(posedge clk); #1;
                end
                in_valid2  = 1'b0;
                out_ready2 = 1'b1;
                repeat (10) @(posedge clk);
                #1;
                check("w13_drained", sb2_q.size(), 0);
                check("w13_count", n_out2, n_in2);
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
